// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding and shared constants for the multi-cycle sequencer
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERROR  = 3'd7
   } seq_state_t;

   localparam int DEFAULT_TIMEOUT = 15;
   localparam int WAIT_W          = 8;

   // FETCH and MEM are the only phases that own the memory port
   function automatic logic is_mem_phase(input seq_state_t s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating memory wait counter with terminal compare
module wait_timer
   import seq_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == WAIT_W'(TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer
// Shares one memory port between instruction fetch and data access.
module cpu_sequencer
   import seq_pkg::*;
#(
   parameter int CW      = 16,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          CLOCK,
   input  logic          CLEAR,
   input  logic          START,
   input  logic          HALT_REQ,
   input  logic          MEM_RD,
   input  logic          MEM_WR,
   input  logic          REG_WR,
   input  logic          MEM_READY,
   output logic          PC_WE,
   output logic          IR_WE,
   output logic          REG_WE,
   output logic          MEM_REQ,
   output logic          MEM_WE,
   output logic          DATA_PHASE,
   output logic          BUSY,
   output logic          HALTED,
   output logic          ERR,
   output logic [CW-1:0] INST_COUNT
);

   seq_state_t state, next_state;
   logic       in_mem_phase;
   logic       timer_clr;
   logic       timer_inc;
   logic       timer_expired;
   logic       mem_both;

   // Outside FETCH/MEM the timer sits at zero, so every entry starts fresh
   assign in_mem_phase = is_mem_phase(state);
   assign timer_clr    = !in_mem_phase || MEM_READY;
   assign timer_inc    = in_mem_phase && !MEM_READY;
   assign mem_both     = MEM_RD && MEM_WR;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (CLOCK),
      .rst     (CLEAR),
      .clr     (timer_clr),
      .inc     (timer_inc),
      .expired (timer_expired)
   );

   always_ff @(posedge CLOCK) begin
      if (CLEAR) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (START) next_state = ST_FETCH;
         ST_FETCH: begin
            if (MEM_READY)          next_state = ST_DECODE;
            else if (timer_expired) next_state = ST_ERROR;
         end
         ST_DECODE: next_state = HALT_REQ ? ST_HALT : ST_EXEC;
         ST_EXEC:   next_state = (MEM_RD || MEM_WR) ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (MEM_READY)          next_state = ST_WB;
            else if (timer_expired) next_state = ST_ERROR;
         end
         ST_WB:     next_state = ST_FETCH;
         ST_HALT:   next_state = ST_HALT;
         ST_ERROR:  next_state = ST_ERROR;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      PC_WE      = 1'b0;
      IR_WE      = 1'b0;
      REG_WE     = 1'b0;
      MEM_REQ    = 1'b0;
      MEM_WE     = 1'b0;
      DATA_PHASE = 1'b0;
      BUSY       = 1'b0;
      HALTED     = 1'b0;
      ERR        = 1'b0;
      case (state)
         ST_FETCH: begin
            MEM_REQ = 1'b1;
            IR_WE   = MEM_READY;
            BUSY    = 1'b1;
         end
         ST_DECODE, ST_EXEC: BUSY = 1'b1;
         ST_MEM: begin
            MEM_REQ    = 1'b1;
            MEM_WE     = MEM_WR;
            DATA_PHASE = 1'b1;
            BUSY       = 1'b1;
         end
         // A combined read+write is carried out as a store, so nothing is written back
         ST_WB: begin
            PC_WE  = 1'b1;
            REG_WE = REG_WR && !mem_both;
            BUSY   = 1'b1;
         end
         ST_HALT:  HALTED = 1'b1;
         ST_ERROR: ERR    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (CLEAR) begin
         INST_COUNT <= '0;
      end else if ((state == ST_WB) || ((state == ST_DECODE) && HALT_REQ)) begin
         INST_COUNT <= INST_COUNT + 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   localparam logic [8:0] O_PC  = 9'h100, O_IR = 9'h080, O_RW = 9'h040, O_RQ  = 9'h020;
   localparam logic [8:0] O_WE  = 9'h010, O_DP = 9'h008, O_BSY = 9'h004, O_HLT = 9'h002;
   localparam logic [8:0] O_ERR = 9'h001;
   localparam int TMO = 15;

   logic CLOCK = 1'b0;
   logic CLEAR, START, HALT_REQ, MEM_RD, MEM_WR, REG_WR, MEM_READY;
   logic PC_WE, IR_WE, REG_WE, MEM_REQ, MEM_WE, DATA_PHASE, BUSY, HALTED, ERR;
   logic [15:0] INST_COUNT;
   logic pc_we4, ir_we4, reg_we4, mem_req4, mem_we4, data_phase4, busy4, halted4, err4;
   logic [3:0] inst_count4;
   logic [8:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       start, halt, rd, wr, rw, ready;
      logic [8:0] exp;
      int         cnt;
   } cyc_t;
   cyc_t plan[$];

   assign outs = {PC_WE, IR_WE, REG_WE, MEM_REQ, MEM_WE, DATA_PHASE, BUSY, HALTED, ERR};

   always #5 CLOCK = ~CLOCK;

   cpu_sequencer #(.CW(16), .TIMEOUT(TMO)) dut (
      .CLOCK(CLOCK), .CLEAR(CLEAR), .START(START), .HALT_REQ(HALT_REQ),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .REG_WR(REG_WR), .MEM_READY(MEM_READY),
      .PC_WE(PC_WE), .IR_WE(IR_WE), .REG_WE(REG_WE), .MEM_REQ(MEM_REQ),
      .MEM_WE(MEM_WE), .DATA_PHASE(DATA_PHASE), .BUSY(BUSY), .HALTED(HALTED),
      .ERR(ERR), .INST_COUNT(INST_COUNT)
   );

   cpu_sequencer #(.CW(4), .TIMEOUT(TMO)) dut4 (
      .CLOCK(CLOCK), .CLEAR(CLEAR), .START(START), .HALT_REQ(HALT_REQ),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .REG_WR(REG_WR), .MEM_READY(MEM_READY),
      .PC_WE(pc_we4), .IR_WE(ir_we4), .REG_WE(reg_we4), .MEM_REQ(mem_req4),
      .MEM_WE(mem_we4), .DATA_PHASE(data_phase4), .BUSY(busy4), .HALTED(halted4),
      .ERR(err4), .INST_COUNT(inst_count4)
   );

   function automatic logic r1();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic cyc();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic do_clear();
      CLEAR = 1; START = 0; HALT_REQ = 0; MEM_RD = 0; MEM_WR = 0; REG_WR = 0; MEM_READY = 0;
      repeat (2) @(posedge CLOCK);
      #1 CLEAR = 0;
   endtask

   task automatic plan_cycle(input logic start, halt, rd, wr, rw, ready,
                             input logic [8:0] e, input int cnt);
      cyc_t c;
      c.start = start; c.halt = halt; c.rd = rd; c.wr = wr; c.rw = rw; c.ready = ready;
      c.exp = e; c.cnt = cnt;
      plan.push_back(c);
   endtask

   task automatic test_reset();
      do_clear();
      @(negedge CLOCK);
      n_checks++;
      if (outs !== 9'h000) begin
         n_fail++; $display("FAIL reset_outs got %h want %h", outs, 9'h000);
      end
      n_checks++;
      if (INST_COUNT !== 16'd0) begin
         n_fail++; $display("FAIL reset_count got %0d want 0", INST_COUNT);
      end
   endtask

   task automatic test_basic();
      logic [8:0] e;
      int ph, ec;
      do_clear();
      START = 1; MEM_READY = 1; REG_WR = 1;
      for (int c = 0; c <= 13; c++) begin
         if (c == 0) begin
            e = 9'h000; ec = 0;
         end else begin
            ph = (c - 1) % 4;
            ec = (c - 1) / 4;
            e  = (ph == 0) ? (O_RQ | O_IR | O_BSY) : (ph == 3) ? (O_PC | O_RW | O_BSY) : O_BSY;
         end
         @(negedge CLOCK);
         n_checks++;
         if (outs !== e) begin
            n_fail++; $display("FAIL basic_outs c=%0d got %h want %h", c, outs, e);
         end
         n_checks++;
         if (INST_COUNT !== 16'(ec)) begin
            n_fail++; $display("FAIL basic_count c=%0d got %0d want %0d", c, INST_COUNT, ec);
         end
         cyc();
      end
   endtask

   task automatic test_mem_ops();
      logic [8:0] tr[$];
      logic       rdy[$];
      logic [8:0] m;
      logic       rd, wr;
      int         w;
      for (int v = 0; v < 3; v++) begin
         rd = (v != 1); wr = (v != 0); w = (v == 0) ? 3 : 0;
         tr.delete(); rdy.delete();
         m = O_RQ | O_DP | O_BSY | (wr ? O_WE : 9'h000);
         tr.push_back(9'h000);              rdy.push_back(1);
         tr.push_back(O_RQ | O_IR | O_BSY); rdy.push_back(1);
         tr.push_back(O_BSY);               rdy.push_back(1);
         tr.push_back(O_BSY);               rdy.push_back(1);
         for (int i = 0; i < w; i++) begin
            tr.push_back(m); rdy.push_back(0);
         end
         tr.push_back(m); rdy.push_back(1);
         tr.push_back(O_PC | O_BSY | ((rd && wr) ? 9'h000 : O_RW)); rdy.push_back(1);
         tr.push_back(O_RQ | O_IR | O_BSY); rdy.push_back(1);
         do_clear();
         START = 1; MEM_RD = rd; MEM_WR = wr; REG_WR = 1;
         foreach (tr[i]) begin
            MEM_READY = rdy[i];
            @(negedge CLOCK);
            n_checks++;
            if (outs !== tr[i]) begin
               n_fail++; $display("FAIL memop v=%0d c=%0d got %h want %h", v, i, outs, tr[i]);
            end
            cyc();
         end
         @(negedge CLOCK);
         n_checks++;
         if (INST_COUNT !== 16'd1) begin
            n_fail++; $display("FAIL memop_count v=%0d got %0d want 1", v, INST_COUNT);
         end
      end
   endtask

   task automatic test_halt();
      logic [8:0] e;
      int ec;
      do_clear();
      START = 1; MEM_READY = 1; REG_WR = 1; HALT_REQ = 1;
      for (int c = 0; c < 12; c++) begin
         if (c >= 3) begin
            START = r1(); MEM_READY = r1(); HALT_REQ = r1();
         end
         e  = (c == 0) ? 9'h000 : (c == 1) ? (O_RQ | O_IR | O_BSY) : (c == 2) ? O_BSY : O_HLT;
         ec = (c >= 3) ? 1 : 0;
         @(negedge CLOCK);
         n_checks++;
         if (outs !== e) begin
            n_fail++; $display("FAIL halt_outs c=%0d got %h want %h", c, outs, e);
         end
         n_checks++;
         if (INST_COUNT !== 16'(ec)) begin
            n_fail++; $display("FAIL halt_count c=%0d got %0d want %0d", c, INST_COUNT, ec);
         end
         cyc();
      end
      do_clear();
      @(negedge CLOCK);
      n_checks++;
      if (outs !== 9'h000) begin
         n_fail++; $display("FAIL halt_clear got %h want %h", outs, 9'h000);
      end
   endtask

   task automatic test_timeout();
      logic [8:0] tr[$];
      logic       rdy[$];
      logic [8:0] m;
      m = O_RQ | O_DP | O_BSY;
      for (int v = 0; v < 3; v++) begin
         tr.delete(); rdy.delete();
         tr.push_back(9'h000); rdy.push_back(0);
         if (v == 0) begin
            for (int i = 0; i < TMO + 1; i++) begin
               tr.push_back(O_RQ | O_BSY); rdy.push_back(0);
            end
         end else begin
            tr.push_back(O_RQ | O_IR | O_BSY); rdy.push_back(1);
            tr.push_back(O_BSY); rdy.push_back(0);
            tr.push_back(O_BSY); rdy.push_back(0);
            for (int i = 0; i < ((v == 1) ? TMO + 1 : TMO); i++) begin
               tr.push_back(m); rdy.push_back(0);
            end
         end
         if (v == 2) begin
            tr.push_back(m); rdy.push_back(1);
            tr.push_back(O_PC | O_RW | O_BSY); rdy.push_back(0);
            tr.push_back(O_RQ | O_BSY); rdy.push_back(0);
         end else begin
            for (int i = 0; i < 4; i++) begin
               tr.push_back(O_ERR); rdy.push_back(r1());
            end
         end
         do_clear();
         START = 1; MEM_RD = (v != 0); REG_WR = 1;
         foreach (tr[i]) begin
            MEM_READY = rdy[i];
            @(negedge CLOCK);
            n_checks++;
            if (outs !== tr[i]) begin
               n_fail++; $display("FAIL timeout v=%0d c=%0d got %h want %h", v, i, outs, tr[i]);
            end
            cyc();
         end
         CLEAR = 1;
         cyc();
         CLEAR = 0; START = 0;
         @(negedge CLOCK);
         n_checks++;
         if (outs !== 9'h000) begin
            n_fail++; $display("FAIL timeout_clear v=%0d got %h want %h", v, outs, 9'h000);
         end
      end
   endtask

   task automatic test_clear_mid();
      do_clear();
      START = 1; MEM_READY = 1; REG_WR = 1;
      repeat (5) cyc();
      MEM_RD = 1;
      repeat (3) cyc();
      MEM_READY = 0;
      repeat (2) cyc();
      @(negedge CLOCK);
      n_checks++;
      if (outs !== (O_RQ | O_DP | O_BSY)) begin
         n_fail++; $display("FAIL clrmid_pre got %h want %h", outs, O_RQ | O_DP | O_BSY);
      end
      n_checks++;
      if (INST_COUNT !== 16'd1) begin
         n_fail++; $display("FAIL clrmid_pre_count got %0d want 1", INST_COUNT);
      end
      CLEAR = 1; MEM_READY = 1;
      cyc();
      CLEAR = 0; START = 0;
      @(negedge CLOCK);
      n_checks++;
      if (outs !== 9'h000) begin
         n_fail++; $display("FAIL clrmid_outs got %h want %h", outs, 9'h000);
      end
      n_checks++;
      if (INST_COUNT !== 16'd0) begin
         n_fail++; $display("FAIL clrmid_count got %0d want 0", INST_COUNT);
      end
   endtask

   task automatic test_wrap();
      int retired;
      retired = 17;
      do_clear();
      START = 1; MEM_READY = 1;
      repeat (1 + 4 * retired) cyc();
      @(negedge CLOCK);
      n_checks++;
      if (inst_count4 !== 4'(retired % 16)) begin
         n_fail++; $display("FAIL wrap_cw4 got %0d want %0d", inst_count4, retired % 16);
      end
      n_checks++;
      if (INST_COUNT !== 16'(retired)) begin
         n_fail++; $display("FAIL wrap_cw16 got %0d want %0d", INST_COUNT, retired);
      end
   endtask

   task automatic test_random_program();
      int cnt, fw, mw;
      logic h, rd, wr, rw;
      logic [8:0] m;
      plan.delete();
      cnt = 0;
      do_clear();
      repeat ($urandom_range(1, 3)) plan_cycle(0, r1(), r1(), r1(), r1(), r1(), 9'h000, 0);
      plan_cycle(1, 0, 0, 0, 0, r1(), 9'h000, 0);
      for (int n = 0; n < 40; n++) begin
         h  = (n == 39);
         rd = r1(); wr = r1(); rw = r1();
         fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
         for (int i = 0; i < fw; i++) plan_cycle(r1(), h, rd, wr, rw, 0, O_RQ | O_BSY, cnt);
         plan_cycle(r1(), h, rd, wr, rw, 1, O_RQ | O_IR | O_BSY, cnt);
         plan_cycle(r1(), h, rd, wr, rw, r1(), O_BSY, cnt);
         if (h) begin
            cnt++;
         end else begin
            plan_cycle(r1(), h, rd, wr, rw, r1(), O_BSY, cnt);
            if (rd || wr) begin
               m = O_RQ | O_DP | O_BSY | (wr ? O_WE : 9'h000);
               for (int i = 0; i < mw; i++) plan_cycle(r1(), h, rd, wr, rw, 0, m, cnt);
               plan_cycle(r1(), h, rd, wr, rw, 1, m, cnt);
            end
            plan_cycle(r1(), h, rd, wr, rw, r1(),
                       O_PC | O_BSY | ((rw && !(rd && wr)) ? O_RW : 9'h000), cnt);
            cnt++;
         end
      end
      repeat (5) plan_cycle(r1(), r1(), r1(), r1(), r1(), r1(), O_HLT, cnt);
      foreach (plan[i]) begin
         START = plan[i].start; HALT_REQ = plan[i].halt; MEM_RD = plan[i].rd;
         MEM_WR = plan[i].wr; REG_WR = plan[i].rw; MEM_READY = plan[i].ready;
         @(negedge CLOCK);
         n_checks++;
         if (outs !== plan[i].exp) begin
            n_fail++; $display("FAIL rand_outs c=%0d got %h want %h", i, outs, plan[i].exp);
         end
         n_checks++;
         if (INST_COUNT !== 16'(plan[i].cnt)) begin
            n_fail++; $display("FAIL rand_count c=%0d got %0d want %0d", i, INST_COUNT, plan[i].cnt);
         end
         cyc();
      end
   endtask

   initial begin
      CLEAR = 1; START = 0; HALT_REQ = 0; MEM_RD = 0; MEM_WR = 0; REG_WR = 0; MEM_READY = 0;
      test_reset();
      test_basic();
      test_mem_ops();
      test_halt();
      test_timeout();
      test_clear_mid();
      test_wrap();
      test_random_program();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit datapath (PC, INS, Registers, ALU, Memory). It converts the single-cycle datapath into a FETCH/DECODE/EXEC/MEM/WB machine sharing one memory port, generating the write enables and memory requests each phase. It sits beside CONTROL: it consumes CONTROL's decoded HALT/memory/register-write intent and gates PC, instruction register, register file and memory.

Parameters:
CW, 16, width of the retired-instruction counter INST_COUNT
TIMEOUT, 15, maximum consecutive wait cycles on MEM_READY before ERROR (1..255)

Ports:
CLOCK  input  1  system clock, all state changes on rising edge
CLEAR  input  1  synchronous reset, active-high
START  input  1  begin execution from IDLE, level, sampled only in IDLE
HALT_REQ  input  1  CONTROL's HALT decode for the current instruction
MEM_RD  input  1  current instruction loads from memory
MEM_WR  input  1  current instruction stores to memory
REG_WR  input  1  current instruction writes the register file
MEM_READY  input  1  memory completes the current request this cycle
PC_WE  output  1  advance PC (one-cycle pulse)
IR_WE  output  1  latch fetched instruction word (one-cycle pulse)
REG_WE  output  1  register file write enable (one-cycle pulse)
MEM_REQ  output  1  memory access request, held until MEM_READY
MEM_WE  output  1  request is a write, valid only with MEM_REQ
DATA_PHASE  output  1  1 = MEM_REQ is a data access, 0 = instruction fetch (address mux select)
BUSY  output  1  state not IDLE/HALTED/ERROR
HALTED  output  1  halt instruction retired
ERR  output  1  memory timeout occurred
INST_COUNT  output  CW  instructions retired since CLEAR

Behaviour:
- CLEAR=1 at a rising edge: state IDLE, wait counter 0, INST_COUNT 0; all outputs 0. CLEAR dominates every other input in every state, including mid-request.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: START=1 -> FETCH; otherwise stay.
- FETCH: MEM_REQ=1, MEM_WE=0, DATA_PHASE=0. MEM_READY=1 -> IR_WE=1 the same cycle (combinational), next DECODE. MEM_READY=0 -> wait counter +1; counter==TIMEOUT with MEM_READY=0 -> ERROR.
- DECODE: one cycle, no enables. HALT_REQ=1 -> HALT (PC not advanced, INST_COUNT +1). Else -> EXEC.
- EXEC: one cycle, no enables (ALU settles). MEM_RD|MEM_WR -> MEM; else -> WB.
- MEM: MEM_REQ=1, DATA_PHASE=1, MEM_WE=MEM_WR. Waits on MEM_READY exactly as FETCH, same TIMEOUT -> ERROR. MEM_READY=1 -> WB. MEM_RD and MEM_WR both 1: treated as write (MEM_WE=1), REG_WE suppressed in WB.
- WB: REG_WE=REG_WR & ~(MEM_RD&MEM_WR); PC_WE=1; INST_COUNT +1; -> FETCH.
- Wait counter: cleared on every entry to FETCH or MEM and on MEM_READY; 8-bit, saturates.
- HALT: HALTED=1, all enables 0; exits only via CLEAR. ERROR: ERR=1, all enables 0; exits only via CLEAR.
- INST_COUNT wraps modulo 2^CW without flag.
- Latency with zero-wait memory (MEM_READY=1 whenever requested): non-memory instruction 4 cycles FETCH->WB; memory instruction 5 cycles. Each wait cycle adds 1.
- START ignored outside IDLE. MEM_READY outside FETCH/MEM ignored.
- Only IR_WE is Mealy; all other outputs decode from state plus the stated level inputs.

Decomposition:
- Package seq_pkg: state encoding constants (3-bit, IDLE=0 ... ERROR=7), default TIMEOUT.
- Sub-module wait_timer: 8-bit clear/increment/saturate counter with terminal-compare output (count==TIMEOUT), instantiated once and shared by FETCH and MEM.

Test Plan:
- CLEAR=1 two cycles, START=1, MEM_READY=1 constant, no mem/halt -> IR_WE at cycle 1, PC_WE and REG_WE (REG_WR=1) at cycle 4, INST_COUNT=3 after 12 cycles.
- Load: MEM_RD=1, REG_WR=1, MEM_READY low 3 cycles in MEM -> MEM_REQ=1 DATA_PHASE=1 MEM_WE=0 held 4 cycles, REG_WE pulse next cycle, instruction takes 8 cycles.
- Store: MEM_WR=1, REG_WR=1 -> MEM_WE=1 in MEM, REG_WE=1 in WB; MEM_RD=MEM_WR=1 -> MEM_WE=1, REG_WE=0.
- HALT_REQ=1 at DECODE -> HALTED=1 next cycle, PC_WE never pulses, INST_COUNT+1, START toggling has no effect until CLEAR.
- TIMEOUT=15, MEM_READY=0 forever in FETCH -> ERR=1 after 16 FETCH cycles, MEM_REQ drops; CLEAR -> IDLE, ERR=0.
- CLEAR asserted mid-MEM wait -> next cycle all outputs 0, INST_COUNT=0; CW=4 with 17 retirements -> INST_COUNT=1.
